// File: rtl/oled_pkg.sv
// Shared types, geometry constants and address helpers for the OLED double-buffered frame store.
package oled_pkg;

    localparam int OLED_W    = 96;
    localparam int OLED_H    = 64;
    localparam int NPIX      = OLED_W * OLED_H;
    localparam int IDX_W     = 13;
    localparam int COLOUR_W  = 16;
    localparam int RAM_DEPTH = 2 * NPIX;
    localparam int RAM_AW    = 14;

    typedef logic [COLOUR_W-1:0] rgb565_t;

    localparam rgb565_t BG_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        WRITE,
        HOLD,
        CLEAR
    } fsm_state_t;

    // y*96 + x without a multiplier: y*64 + y*32 + x
    function automatic logic [IDX_W-1:0] pixel_addr(input logic [6:0] x, input logic [5:0] y);
        logic [IDX_W-1:0] y_ext;
        y_ext = IDX_W'(y);
        return (y_ext << 6) + (y_ext << 5) + IDX_W'(x);
    endfunction

    // Banks are packed back to back (bank 1 starts at NPIX) so the RAM is exactly 2*NPIX deep
    function automatic logic [RAM_AW-1:0] ram_addr(input logic bank, input logic [IDX_W-1:0] idx);
        return RAM_AW'(idx) + (bank ? RAM_AW'(NPIX) : '0);
    endfunction

endpackage

// File: rtl/oled_frame_server_if.sv
// Renderer write bus into the frame server: valid/ready handshake carrying one pixel per beat.
interface oled_frame_server_if;
    import oled_pkg::*;

    logic       wr_valid;
    logic       wr_ready;
    logic [6:0] wr_x;
    logic [5:0] wr_y;
    rgb565_t    wr_colour;
    logic       wr_last;

    modport master (
        output wr_valid, wr_x, wr_y, wr_colour, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_colour, wr_last,
        output wr_ready
    );

endinterface

// File: rtl/fb_dp_ram.sv
// Simple dual-port frame RAM holding both banks: one write port, one registered read port.
module fb_dp_ram
    import oled_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] waddr,
    input  rgb565_t           wdata,
    input  logic [RAM_AW-1:0] raddr,
    output rgb565_t           rdata
);

    rgb565_t mem [0:RAM_DEPTH-1];
    rgb565_t rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/oled_frame_server.sv
// Double-buffered OLED frame store; banks swap only on frame_begin once a full frame is written.
// Optional: define CLEAR_ON_SWAP_EN to fill the new back bank with BG_COLOUR after every swap.
module oled_frame_server
    import oled_pkg::*;
#(
    parameter rgb565_t BG_COLOUR = BG_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_begin,
    input  logic [IDX_W-1:0]   pixel_index,
    output rgb565_t            pixel_data,
    oled_frame_server_if.slave wr,
    output logic               swap_pending,
    output logic [7:0]         frame_count
);

    fsm_state_t state_reg;
    logic       front_reg;
    logic       wr_ready_reg;
    logic       swap_pending_reg;
    logic       show_ram_reg;
    logic [7:0] frame_count_reg;
`ifdef CLEAR_ON_SWAP_EN
    logic [IDX_W-1:0] clr_idx_reg;
`endif

    logic              wr_accept;
    logic              wr_in_range;
    logic              pix_in_range;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [RAM_AW-1:0] ram_raddr;
    rgb565_t           ram_wdata;
    rgb565_t           ram_rdata;

    assign wr_accept    = wr.wr_valid && wr_ready_reg;
    assign wr_in_range  = (wr.wr_x < 7'(OLED_W)) && ({1'b0, wr.wr_y} < 7'(OLED_H));
    assign pix_in_range = pixel_index < IDX_W'(NPIX);

    // Writes always land in the back bank; the display only ever reads the front one
    always_comb begin
        ram_we    = wr_accept && wr_in_range;
        ram_waddr = ram_addr(~front_reg, pixel_addr(wr.wr_x, wr.wr_y));
        ram_wdata = wr.wr_colour;
`ifdef CLEAR_ON_SWAP_EN
        if (state_reg == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = ram_addr(~front_reg, clr_idx_reg);
            ram_wdata = BG_COLOUR;
        end
`endif
    end

    assign ram_raddr = ram_addr(front_reg, pix_in_range ? pixel_index : '0);

    fb_dp_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= WRITE;
            front_reg        <= 1'b0;
            wr_ready_reg     <= 1'b1;
            swap_pending_reg <= 1'b0;
            show_ram_reg     <= 1'b0;
            frame_count_reg  <= 8'd0;
`ifdef CLEAR_ON_SWAP_EN
            clr_idx_reg      <= '0;
`endif
        end else begin
            show_ram_reg <= pix_in_range;
            case (state_reg)
                WRITE: begin
                    // frame_begin is ignored here, so a coincident wr_last waits for the next one
                    if (wr_accept && wr.wr_last) begin
                        state_reg        <= HOLD;
                        swap_pending_reg <= 1'b1;
                        wr_ready_reg     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (frame_begin) begin
                        front_reg        <= ~front_reg;
                        swap_pending_reg <= 1'b0;
                        frame_count_reg  <= frame_count_reg + 8'd1;
`ifdef CLEAR_ON_SWAP_EN
                        state_reg        <= CLEAR;
                        clr_idx_reg      <= '0;
`else
                        state_reg        <= WRITE;
                        wr_ready_reg     <= 1'b1;
`endif
                    end
                end
`ifdef CLEAR_ON_SWAP_EN
                CLEAR: begin
                    if (clr_idx_reg == IDX_W'(NPIX - 1)) begin
                        state_reg    <= WRITE;
                        wr_ready_reg <= 1'b1;
                    end else begin
                        clr_idx_reg <= clr_idx_reg + IDX_W'(1);
                    end
                end
`endif
                default: begin
                    state_reg        <= WRITE;
                    wr_ready_reg     <= 1'b1;
                    swap_pending_reg <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range reads and the first cycle after reset return the background colour
    assign pixel_data   = show_ram_reg ? ram_rdata : BG_COLOUR;
    assign wr.wr_ready  = wr_ready_reg;
    assign swap_pending = swap_pending_reg;
    assign frame_count  = frame_count_reg;

endmodule

// File: tb/tb_oled_frame_server.sv
// Randomized self-checking bench for oled_frame_server against a two-bank array model.
module tb_oled_frame_server;
    import oled_pkg::*;

    localparam logic [15:0] BG = 16'h0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_begin = 1'b0;
    logic [12:0] pixel_index = '0;
    rgb565_t     pixel_data;
    logic        swap_pending;
    logic [7:0]  frame_count;

    oled_frame_server_if wr_bus ();

    oled_frame_server #(.BG_COLOUR(BG)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_begin  (frame_begin),
        .pixel_index  (pixel_index),
        .pixel_data   (pixel_data),
        .wr           (wr_bus),
        .swap_pending (swap_pending),
        .frame_count  (frame_count)
    );

    always #80 clk = ~clk;

    // Behavioural model: two banks of pixels, a front pointer, a pending flag, a swap counter
    logic [15:0] m_mem   [2][NPIX];
    bit          m_known [2][NPIX];
    int          m_front;
    int          m_count;
    int          m_clear_left;
    bit          m_pend;
    bit          m_accepted;
    logic [15:0] e_pix;
    bit          e_known;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;
    bit rand_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int x;
        int y;
        bit rdy;
        m_accepted = 0;
        if (!reset) begin
            m_front = 0; m_pend = 0; m_count = 0; m_clear_left = 0;
            e_pix = BG; e_known = 1;
            return;
        end
        if (pixel_index < NPIX) begin
            e_pix   = m_mem[m_front][pixel_index];
            e_known = m_known[m_front][pixel_index];
        end else begin
            e_pix   = BG;
            e_known = 1;
        end
        rdy = !m_pend && (m_clear_left == 0);
        x = int'(wr_bus.wr_x);
        y = int'(wr_bus.wr_y);
        if (m_clear_left > 0) begin
            m_mem[1-m_front][NPIX-m_clear_left]   = BG;
            m_known[1-m_front][NPIX-m_clear_left] = 1;
            m_clear_left--;
        end else if (wr_bus.wr_valid && rdy) begin
            m_accepted = 1;
            if (x < OLED_W && y < OLED_H) begin
                m_mem[1-m_front][y*OLED_W+x]   = wr_bus.wr_colour;
                m_known[1-m_front][y*OLED_W+x] = 1;
            end
            if (wr_bus.wr_last) m_pend = 1;
        end else if (m_pend && frame_begin) begin
            m_front = 1 - m_front;
            m_pend  = 0;
            m_count = (m_count + 1) % 256;
`ifdef CLEAR_ON_SWAP_EN
            m_clear_left = NPIX;
`endif
        end
    endtask

    // Single compare process: every cycle, all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (e_known) check("pixel_data", 32'(pixel_data), 32'(e_pix));
            check("wr_ready", 32'(wr_bus.wr_ready), 32'(!m_pend && (m_clear_left == 0)));
            check("swap_pending", 32'(swap_pending), 32'(m_pend));
            check("frame_count", 32'(frame_count), 32'(m_count));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (rand_idx) pixel_index = 13'($urandom_range(0, 8191));
    endtask

    task automatic write_px(input int x, input int y, input logic [15:0] c, input bit last, input bit fb);
        int n = 0;
        wr_bus.wr_valid  = 1'b1;
        wr_bus.wr_x      = 7'(x);
        wr_bus.wr_y      = 6'(y);
        wr_bus.wr_colour = c;
        wr_bus.wr_last   = last;
        frame_begin      = fb;
        do begin
            tick();
            n++;
        end while (!m_accepted && n < 20000);
        if (!m_accepted) check("write_timeout", 32'(m_accepted), 32'd1);
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_last  = 1'b0;
        frame_begin     = 1'b0;
    endtask

    task automatic pulse_fb();
        frame_begin = 1'b1;
        tick();
        frame_begin = 1'b0;
    endtask

    task automatic sweep();
        rand_idx = 0;
        for (int i = 0; i < NPIX; i++) begin
            pixel_index = 13'(i);
            tick();
        end
        tick();
    endtask

    task automatic rand_frame(input int n);
        int g = 0;
        rand_idx = 1;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_bus.wr_valid = 1'b0;
                frame_begin = ($urandom_range(0, 30) == 0);
                tick();
                frame_begin = 1'b0;
            end
            write_px(int'($urandom_range(0, 105)), int'($urandom_range(0, 63)), 16'($urandom),
                     k == n - 1, $urandom_range(0, 30) == 0);
        end
        // Writes attempted while the frame waits for frame_begin must be refused
        while (m_pend && g < 1000) begin
            wr_bus.wr_valid  = 1'($urandom_range(0, 1));
            wr_bus.wr_x      = 7'($urandom_range(0, 95));
            wr_bus.wr_y      = 6'($urandom_range(0, 63));
            wr_bus.wr_colour = 16'($urandom);
            wr_bus.wr_last   = 1'($urandom_range(0, 1));
            frame_begin      = ($urandom_range(0, 9) == 0);
            tick();
            g++;
        end
        check("swap_timeout", 32'(m_pend), 32'd0);
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_last  = 1'b0;
        frame_begin     = 1'b0;
    endtask

    initial begin
        int cnt0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NPIX; i++) m_known[b][i] = 0;
        m_front = 0; m_pend = 0; m_count = 0; m_clear_left = 0;
        e_pix = BG; e_known = 0;
        wr_bus.wr_valid = 1'b0; wr_bus.wr_x = '0; wr_bus.wr_y = '0;
        wr_bus.wr_colour = '0; wr_bus.wr_last = 1'b0;

        tick();
        chk_en = 1;
        tick();
        reset = 1'b1;

        // Give both banks known contents (all background) so reads are predictable
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NPIX; i++)
                write_px(i % OLED_W, i / OLED_W, BG, i == NPIX - 1, 1'b0);
            pulse_fb();
        end

        // 1) reset state and full read sweep
        reset = 1'b0;
        tick();
        check("reset_pixel", 32'(pixel_data), 32'h0);
        check("reset_ready", 32'(wr_bus.wr_ready), 32'd1);
        check("reset_count", 32'(frame_count), 32'd0);
        check("reset_pending", 32'(swap_pending), 32'd0);
        reset = 1'b1;
        sweep();
        check("sweep_last", 32'(pixel_data), 32'h0);

        // 2) single pixel frame then swap
        write_px(5, 3, 16'hF800, 1'b1, 1'b0);
        check("t2_pending", 32'(swap_pending), 32'd1);
        repeat (3) tick();
        check("t2_still_pending", 32'(swap_pending), 32'd1);
        pulse_fb();
        check("t2_count", 32'(frame_count), 32'd1);
        check("t2_pending_clr", 32'(swap_pending), 32'd0);
        pixel_index = 13'd293;
        tick();
        check("t2_pixel_293", 32'(pixel_data), 32'hF800);

        // 3) random frames with concurrent random reads
        for (int f = 0; f < 5; f++) rand_frame(int'($urandom_range(100, 600)));

        // 4) wr_last coinciding with frame_begin defers the swap
        cnt0 = m_count;
        write_px(10, 10, 16'h07E0, 1'b1, 1'b1);
        check("t4_pending", 32'(swap_pending), 32'd1);
        check("t4_no_swap", 32'(frame_count), 32'(cnt0));
        pulse_fb();
        check("t4_swap", 32'(frame_count), 32'((cnt0 + 1) % 256));

        // 5) out-of-range write is accepted but not stored; out-of-range read is background
        write_px(100, 10, 16'h1234, 1'b1, 1'b0);
        check("t5_pending", 32'(swap_pending), 32'd1);
        pixel_index = 13'd6200;
        tick();
        check("t5_oob_read", 32'(pixel_data), 32'(BG));
        pulse_fb();
        sweep();

        // 6) frame counter wraps after 256 swaps
        cnt0 = m_count;
`ifdef CLEAR_ON_SWAP_EN
        for (int s = 0; s < 3; s++) begin
`else
        for (int s = 0; s < 256; s++) begin
`endif
            rand_idx = 1;
            write_px(int'($urandom_range(0, 95)), int'($urandom_range(0, 63)), 16'($urandom), 1'b1, 1'b0);
            pulse_fb();
        end
`ifndef CLEAR_ON_SWAP_EN
        check("wrap_count", 32'(frame_count), 32'(cnt0));
`endif
        tick();
        sweep();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
